// File: rtl/output_layer_mac.sv
// rtl/output_layer_mac.sv - ten-lane signed MAC output layer with bias, score hold window and result pulse
module output_layer_mac #(
  parameter int N_HIDDEN = 32,
  parameter int A_W      = 8,
  parameter int W_W      = 8,
  parameter int B_W      = 16,
  parameter int HOLD_CYC = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [A_W-1:0]           in_act,
  input  logic [10*W_W-1:0]        in_w,
  input  logic [10*B_W-1:0]        bias,
  output logic                     busy,
  output logic                     out_valid,
  output logic signed [25:0]       s0,
  output logic signed [25:0]       s1,
  output logic signed [25:0]       s2,
  output logic signed [25:0]       s3,
  output logic signed [25:0]       s4,
  output logic signed [25:0]       s5,
  output logic signed [25:0]       s6,
  output logic signed [25:0]       s7,
  output logic signed [25:0]       s8,
  output logic signed [25:0]       s9
);

  localparam int ACC_W = 26;
  localparam int P_W   = A_W + W_W;
  localparam int CNT_W = $clog2(N_HIDDEN + 1);
  localparam int HC_W  = $clog2(HOLD_CYC + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACC,
    S_HOLD
  } state_t;

  state_t                  state;
  logic [CNT_W-1:0]        beat_cnt;
  logic [HC_W-1:0]         hold_cnt;
  logic signed [ACC_W-1:0] acc   [10];
  logic signed [ACC_W-1:0] score [10];
  logic signed [P_W-1:0]   prod_raw [10];
  logic signed [ACC_W-1:0] prod  [10];
  logic signed [ACC_W-1:0] bias_x [10];
  logic                    accept;

  // Ready is forced low while reset is held so nothing upstream sees a phantom accept.
  assign in_ready = rst && (state != S_HOLD);
  assign busy     = (state == S_ACC);
  assign accept   = in_valid && in_ready;

  // Per-lane signed product and bias, both sign-extended to the accumulator width.
  always_comb begin
    for (int k = 0; k < 10; k++) begin
      prod_raw[k] = $signed(in_act) * $signed(in_w[k*W_W +: W_W]);
      prod[k]     = {{(ACC_W-P_W){prod_raw[k][P_W-1]}}, prod_raw[k]};
      bias_x[k]   = {{(ACC_W-B_W){bias[k*B_W+B_W-1]}}, bias[k*B_W +: B_W]};
    end
  end

  // Frame sequencer: accumulate N_HIDDEN beats, publish scores, then block input for the hold window.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_IDLE;
      beat_cnt  <= '0;
      hold_cnt  <= '0;
      out_valid <= 1'b0;
      for (int k = 0; k < 10; k++) begin
        acc[k]   <= '0;
        score[k] <= '0;
      end
    end else begin
      out_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (accept) begin
            for (int k = 0; k < 10; k++) acc[k] <= bias_x[k] + prod[k];
            beat_cnt <= CNT_W'(1);
            state    <= S_ACC;
          end
        end
        S_ACC: begin
          if (accept) begin
            if (beat_cnt == CNT_W'(N_HIDDEN - 1)) begin
              for (int k = 0; k < 10; k++) score[k] <= acc[k] + prod[k];
              out_valid <= 1'b1;
              beat_cnt  <= '0;
              hold_cnt  <= '0;
              state     <= S_HOLD;
            end else begin
              for (int k = 0; k < 10; k++) acc[k] <= acc[k] + prod[k];
              beat_cnt <= beat_cnt + CNT_W'(1);
            end
          end
        end
        S_HOLD: begin
          if (hold_cnt == HC_W'(HOLD_CYC - 1)) begin
            state <= S_IDLE;
          end else begin
            hold_cnt <= hold_cnt + HC_W'(1);
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign s0 = score[0];
  assign s1 = score[1];
  assign s2 = score[2];
  assign s3 = score[3];
  assign s4 = score[4];
  assign s5 = score[5];
  assign s6 = score[6];
  assign s7 = score[7];
  assign s8 = score[8];
  assign s9 = score[9];

endmodule
